// File: rtl/stream_demux_if.sv
// Handshake bundle for stream_demux: one producer-side stream in, NUM_OUT consumer streams out.
// slave = demux side, master = producer/consumer side.
interface stream_demux_if #(
  parameter int DATA_W  = 8,
  parameter int NUM_OUT = 2,
  parameter int SEL_W   = 1
);
  logic                      in_valid;
  logic                      in_ready;
  logic [DATA_W-1:0]         in_data;
  logic                      in_last;
  logic [SEL_W-1:0]          in_sel;
  logic [NUM_OUT-1:0]        out_valid;
  logic [NUM_OUT-1:0]        out_ready;
  logic [NUM_OUT*DATA_W-1:0] out_data;
  logic [NUM_OUT-1:0]        out_last;
  logic                      err_sel;

  modport master (
    output in_valid, in_data, in_last, in_sel, out_ready,
    input  in_ready, out_valid, out_data, out_last, err_sel
  );

  modport slave (
    input  in_valid, in_data, in_last, in_sel, out_ready,
    output in_ready, out_valid, out_data, out_last, err_sel
  );
endinterface

// File: rtl/stream_demux.sv
// Registered 1:NUM_OUT packet demux; route latched on first beat, held until last is accepted.
// Optional DEMUX_STATS_EN adds per-channel handshake counters and an invalid-select drop counter.
module stream_demux #(
  parameter int DATA_W  = 8,
  parameter int NUM_OUT = 2,
  parameter int SEL_W   = 1
) (
  input  logic               clk,
  input  logic               reset,
  stream_demux_if.slave      bus
`ifdef DEMUX_STATS_EN
  ,
  output logic [NUM_OUT*16-1:0] beat_count,
  output logic [15:0]           drop_count
`endif
);

  if (NUM_OUT < 2 || NUM_OUT > 8 || SEL_W != $clog2(NUM_OUT)) begin : g_bad_param
    $error("stream_demux: NUM_OUT must be 2..8 and SEL_W must equal clog2(NUM_OUT)");
  end

  typedef enum logic {IDLE, ROUTE} state_t;

  state_t                    state;
  logic [SEL_W-1:0]          route_sel;
  logic                      route_bad;
  logic                      err_q;
  logic [NUM_OUT-1:0]        vld_q;
  logic [NUM_OUT-1:0]        last_q;
  logic [NUM_OUT*DATA_W-1:0] dat_q;

  logic [SEL_W-1:0] tgt;
  logic             tgt_ok;
  logic             tgt_free;
  logic             sel_in_range;
  logic             in_ready;
  logic             accept;

  assign sel_in_range = ({1'b0, bus.in_sel} < (SEL_W+1)'(NUM_OUT));

  // An invalid target always accepts so the packet can be swallowed.
  always_comb begin
    tgt      = (state == ROUTE) ? route_sel  : bus.in_sel;
    tgt_ok   = (state == ROUTE) ? ~route_bad : sel_in_range;
    tgt_free = 1'b1;
    for (int k = 0; k < NUM_OUT; k++) begin
      if (tgt_ok && tgt == SEL_W'(k)) begin
        tgt_free = ~vld_q[k] | bus.out_ready[k];
      end
    end
  end

  assign in_ready = ~reset & tgt_free;
  assign accept   = bus.in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      route_sel <= '0;
      route_bad <= 1'b0;
      err_q     <= 1'b0;
      vld_q     <= '0;
      last_q    <= '0;
      dat_q     <= '0;
    end else begin
      err_q <= accept & (state == IDLE) & ~tgt_ok;

      for (int k = 0; k < NUM_OUT; k++) begin
        if (accept && tgt_ok && tgt == SEL_W'(k)) begin
          vld_q[k]                   <= 1'b1;
          last_q[k]                  <= bus.in_last;
          dat_q[k*DATA_W +: DATA_W]  <= bus.in_data;
        end else if (bus.out_ready[k]) begin
          vld_q[k] <= 1'b0;
        end
      end

      case (state)
        IDLE: begin
          if (accept && !bus.in_last) begin
            state     <= ROUTE;
            route_sel <= bus.in_sel;
            route_bad <= ~tgt_ok;
          end
        end
        ROUTE: begin
          if (accept && bus.in_last) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = vld_q;
  assign bus.out_data  = dat_q;
  assign bus.out_last  = last_q;
  assign bus.err_sel   = err_q;

`ifdef DEMUX_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      beat_count <= '0;
      drop_count <= '0;
    end else begin
      for (int k = 0; k < NUM_OUT; k++) begin
        if (vld_q[k] && bus.out_ready[k]) begin
          beat_count[k*16 +: 16] <= beat_count[k*16 +: 16] + 16'd1;
        end
      end
      if (accept && !tgt_ok) begin
        drop_count <= drop_count + 16'd1;
      end
    end
  end
`endif

endmodule
